// File: rtl/writeback_stage.sv
// writeback_stage: registered MEM/WB writeback with multdiv pending-result FIFO arbitration.
// Define WRITEBACK_FORWARD_EN to drive the fwd_* bypass copy of the write port.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MD_DEPTH = 4,
    parameter int CNT_W    = 32,
    parameter int EXC_REG  = 30,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_insn,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_dmem_data,
    input  logic              in_exception,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_rd,
    input  logic              md_is_div,
    input  logic [DATA_W-1:0] md_data,
    input  logic              md_exception,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);
    localparam int AW = $clog2(MD_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = REG_W + DATA_W + 2;

    logic              valid_q, valid_d, exc_q, exc_d;
    logic [DATA_W-1:0] insn_q, insn_d, alu_q, alu_d, dmem_q, dmem_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [EW-1:0]     mem_q [MD_DEPTH];
    logic [EW-1:0]     mem_d [MD_DEPTH];

    logic [4:0]        op, aluop;
    logic              is_r, is_addi, is_lw, is_jal, is_setx, pipe_wr, push, pop;
    logic [REG_W-1:0]  pipe_reg, h_rd, h_reg;
    logic [DATA_W-1:0] pipe_data, exc_code, h_data, h_val;
    logic              h_div, h_exc;
    logic              unused_ok;

    assign unused_ok = ^{insn_q[21:7], insn_q[1:0]};

    always_comb begin
        op        = insn_q[31:27];
        aluop     = insn_q[6:2];
        is_r      = op == 5'b00000;
        is_addi   = op == 5'b00101;
        is_lw     = op == 5'b01000;
        is_jal    = op == 5'b00011;
        is_setx   = op == 5'b10101;
        pipe_wr   = valid_q && (is_r || is_addi || is_lw || is_jal || is_setx || exc_q);
        pipe_reg  = (exc_q || is_setx) ? REG_W'(EXC_REG) : is_jal ? REG_W'(LINK_REG) : insn_q[26:22];
        exc_code  = (is_r && aluop == 5'd0) ? DATA_W'(1) : is_addi ? DATA_W'(2) :
                    (is_r && aluop == 5'd1) ? DATA_W'(3) : '0;
        pipe_data = exc_q ? exc_code : is_lw ? dmem_q : alu_q;
        {h_rd, h_div, h_data, h_exc} = mem_q[rd_ptr_q];
        h_reg     = h_exc ? REG_W'(EXC_REG) : h_rd;
        h_val     = h_exc ? (h_div ? DATA_W'(5) : DATA_W'(4)) : h_data;
        // A suppressed r0 pipe write still owns the port, so the head waits.
        pop       = !pipe_wr && count_q != '0;
        md_ready  = !reset && count_q != CW'(MD_DEPTH);
        push      = md_valid && md_ready;
        ctrl_writeEnable = pipe_wr ? (exc_q || pipe_reg != '0) : (pop && (h_exc || h_rd != '0));
        ctrl_writeReg    = pipe_wr ? pipe_reg : pop ? h_reg : '0;
        data_writeReg    = pipe_wr ? pipe_data : pop ? h_val : '0;
        valid_d   = in_valid;
        insn_d    = in_insn;
        alu_d     = in_alu_data;
        dmem_d    = in_dmem_data;
        exc_d     = in_exception;
        mem_d     = mem_q;
        if (push) mem_d[wr_ptr_q] = {md_rd, md_is_div, md_data, md_exception};
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        retire_d  = retire_q + CNT_W'(in_valid);
    end

`ifdef WRITEBACK_FORWARD_EN
    assign fwd_valid = ctrl_writeEnable;
    assign fwd_reg   = ctrl_writeReg;
    assign fwd_data  = data_writeReg;
`else
    assign fwd_valid = 1'b0;
    assign fwd_reg   = '0;
    assign fwd_data  = '0;
`endif

    assign retire_count = retire_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            exc_q    <= 1'b0;
            insn_q   <= '0;
            alu_q    <= '0;
            dmem_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            retire_q <= '0;
        end else begin
            valid_q  <= valid_d;
            exc_q    <= exc_d;
            insn_q   <= insn_d;
            alu_q    <= alu_d;
            dmem_q   <= dmem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            retire_q <= retire_d;
        end
        mem_q <= mem_d;
    end
endmodule
